jtopl_eg_adv: RTL and testbench
===============================

Name: jtopl_eg_adv

Overview:
Sequential envelope-advance engine for the OPL envelope generator, and the consumer end of the envelope control decision. Stores per-slot attenuation and state for 18 operator slots in a circulating shift register. It presents the current slot's eg/state to the control logic and takes back the base_rate/state_next it returns. Runs a global frame counter, derives rate-dependent step timing, and applies the attack, decay or release arithmetic before writing the slot back.

Parameters:
SLOTS, 18, number of operator slots in the circulating store (≥2)
CNTW, 15, width of the global envelope counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cen  in  1  clock enable; all state advances only when cen=1
zero  in  1  high during slot 0 of each frame; qualifies counter increment
base_rate  in  5  rate for the current slot from control: {R[3:0],lsb}
state_next  in  3  next state for the current slot (001 ATTACK, 010 DECAY, 100 HOLD, 000 RELEASE)
ksr  in  1  key-scale-rate select for current slot
keycode  in  4  {block[2:0],fnum_msb} of current slot
eg_out  out  10  attenuation of the slot at the store head (feeds control eg input)
state_out  out  3  state of the slot at the store head (feeds control state_in)
eg_cnt  out  CNTW  global envelope counter (debug/observe)

Behaviour:
- Reset (async, rst=1): every slot eg=10'h3FF, state=RELEASE; eg_cnt=0; eg_out=10'h3FF; state_out=000.
- Store: SLOTS-deep shift register of {state,eg}. Head = slot presented on eg_out/state_out, driven combinationally from the last stage. On cen, the head slot's updated value enters stage 0 and all stages shift by one. Each slot is therefore updated exactly once per SLOTS cen cycles. Loop latency through external control is 0 cycles.
- eg_cnt increments on cen & zero, once per frame. Wraps 2^CNTW-1 → 0. The value used for slot k's step decision is the pre-increment value in the same cycle.
- Effective rate: rate6 = 0 if base_rate==0, else min(63, {base_rate,1'b0} + koff), where koff = ksr ? keycode : keycode>>2. R = rate6[5:2], f = rate6[1:0].
- Step pattern by f: 0→8'b10101010, 1→8'b11101010, 2→8'b11101110, 3→8'b11111110.
- Step timing for R<12:
  - sh = 12−R.
  - step = (eg_cnt[sh-1:0]==0) & pattern[eg_cnt[sh+2:sh]].
  - inc = step ? 1 : 0.
  - For R=0, step=0.
- Step timing for R≥12: step=1 and inc = R−11 (1..4).
- ATTACK with next state ATTACK:
  - R=15 → eg=0.
  - Otherwise dec = (eg*inc)>>3; if dec==0 & inc!=0 & eg!=0 then dec=1; eg −= dec, floor 0.
- DECAY or RELEASE with next state unchanged: eg = min(10'h3FF, eg+inc).
- HOLD: eg unchanged.
- State transition: written state = state_next. On ATTACK→DECAY (eg reached 0), eg is not modified that cycle.
- cen=0: no store shift, no counter change, outputs hold.
- Keyon mid-release: state_next=ATTACK overrides regardless of eg. Attack starts from the current eg with no reset to 3FF.
- Reset asserted mid-frame: all slots return to reset values immediately; the slot index realigns via zero.

Optional Feature:
JTOPL_EG_KSR_EN
- Defined: koff computed from ksr/keycode as above.
- Undefined: koff=0, ksr and keycode ports present but ignored. Rate depends on base_rate only.

Decomposition:
- Package jtopl_eg_pkg:
  - state encodings ATTACK/DECAY/HOLD/RELEASE (shared with control block).
  - EG_MAX=10'h3FF.
  - step pattern constants.
  - rate saturation constant 63.
- Sub-module jtopl_eg_step: combinational rate/koff/step/inc computation from base_rate, ksr, keycode, eg_cnt. Top holds the store, counter and arithmetic.

Test Plan:
- Release after reset: assert then drop rst, run 2 frames with state_next=000, base_rate=5'h1F → all slots eg_out=3FF, state_out=000, eg_cnt=2.
- Instant attack: slot 0 state_next=ATTACK, base_rate=5'h1E (R=15), ksr=0, keycode=0 → slot 0 eg=0 on its next visit, other slots remain 3FF.
- Slow decay timing: slot 3 in DECAY, base_rate=5'h08 (R=4,f=0), koff=0 → eg increments by 1 only on frames where eg_cnt[7:0]==0 and pattern bit set; after 512 frames eg increased by exactly 1.
- Saturation: slot in RELEASE at eg=3FE, base_rate=5'h1F (R=15, inc=4) → eg=3FF next visit and remains 3FF.
- KSR (macro defined): base_rate=5'h10, ksr=1, keycode=4'hF → rate6=47, R=11. With macro undefined → rate6=32, R=8. Check step frequency differs accordingly.
- cen gating and hold: cen=0 for 100 cycles mid-frame → eg_out, state_out and eg_cnt unchanged. HOLD slot with any base_rate keeps eg constant over 4 frames.

Source files
------------

// File: rtl/jtopl_eg_pkg.sv
// Shared definitions for the OPL envelope generator.
// Holds the state encodings used by the advance engine and the control block,
// the attenuation ceiling, the per-fraction step patterns, the rate ceiling
// and the packed slot record kept in the circulating store.
package jtopl_eg_pkg;

  typedef enum logic [2:0] {
    ST_RELEASE = 3'b000,
    ST_ATTACK  = 3'b001,
    ST_DECAY   = 3'b010,
    ST_HOLD    = 3'b100
  } eg_state_e;

  localparam logic [9:0] EG_MAX   = 10'h3FF;
  localparam logic [5:0] RATE_MAX = 6'd63;

  localparam logic [7:0] STEP_PAT0 = 8'b10101010;
  localparam logic [7:0] STEP_PAT1 = 8'b11101010;
  localparam logic [7:0] STEP_PAT2 = 8'b11101110;
  localparam logic [7:0] STEP_PAT3 = 8'b11111110;

  typedef struct packed {
    eg_state_e  state;
    logic [9:0] eg;
  } eg_slot_t;

  // Step pattern selected by the fractional part of the effective rate.
  function automatic logic [7:0] step_pattern(input logic [1:0] frac);
    case (frac)
      2'd0:    step_pattern = STEP_PAT0;
      2'd1:    step_pattern = STEP_PAT1;
      2'd2:    step_pattern = STEP_PAT2;
      default: step_pattern = STEP_PAT3;
    endcase
  endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// Combinational rate / step computation for the slot at the store head.
// Ports:
//   base_rate_i  {R[3:0],lsb} from control
//   ksr_i        key-scale-rate select
//   keycode_i    {block,fnum_msb}
//   eg_cnt_i     global envelope counter (pre-increment value)
//   rate_o       effective rate R = rate6[5:2]
//   inc_o        attenuation increment for this visit (0..4)
// Macro JTOPL_EG_KSR_EN enables the key-scale rate offset; without it the
// rate depends on base_rate only and ksr_i/keycode_i are ignored.
module jtopl_eg_step
  import jtopl_eg_pkg::*;
#(
  parameter int unsigned CNTW = 15
) (
  input  logic [4:0]      base_rate_i,
  input  logic            ksr_i,
  input  logic [3:0]      keycode_i,
  input  logic [CNTW-1:0] eg_cnt_i,
  output logic [3:0]      rate_o,
  output logic [2:0]      inc_o
);

  logic [3:0] koff;

`ifdef JTOPL_EG_KSR_EN
  assign koff = ksr_i ? keycode_i : {2'b00, keycode_i[3:2]};
`else
  logic unused_ksr;
  assign unused_ksr = ^{ksr_i, keycode_i};
  assign koff       = 4'd0;
`endif

  logic [6:0]      rate_sum;
  logic [5:0]      rate6;
  logic [7:0]      pattern;
  logic [3:0]      sh;
  logic [CNTW-1:0] low_mask;
  logic [2:0]      pat_idx;

  // Saturated effective rate, then either per-cycle increment (R>=12)
  // or counter-gated single steps (R<12).
  always_comb begin
    rate_sum = {1'b0, base_rate_i, 1'b0} + {3'b000, koff};
    if (base_rate_i == 5'd0)
      rate6 = 6'd0;
    else if (rate_sum > {1'b0, RATE_MAX})
      rate6 = RATE_MAX;
    else
      rate6 = rate_sum[5:0];
    rate_o   = rate6[5:2];
    pattern  = step_pattern(rate6[1:0]);
    // sh is only meaningful for 1<=R<=11; wraps harmlessly otherwise
    sh       = 4'd12 - rate_o;
    low_mask = (CNTW'(1) << sh) - CNTW'(1);
    pat_idx  = 3'(eg_cnt_i >> sh);
    inc_o    = 3'd0;
    if (rate_o >= 4'd12)
      inc_o = 3'(rate_o - 4'd11);
    else if (rate_o != 4'd0 && (eg_cnt_i & low_mask) == '0 && pattern[pat_idx])
      inc_o = 3'd1;
  end

endmodule

// File: rtl/jtopl_eg_adv.sv
// Envelope-advance engine: circulating per-slot {state,eg} store, global
// envelope counter and attack/decay/release arithmetic.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cen           clock enable for all state
//   zero          marks slot 0 of a frame; advances eg_cnt
//   base_rate     rate of the head slot from control
//   state_next    next state of the head slot from control
//   ksr, keycode  key-scale-rate inputs (used only with JTOPL_EG_KSR_EN)
//   eg_out        attenuation of the head slot
//   state_out     state of the head slot
//   eg_cnt        global envelope counter
module jtopl_eg_adv
  import jtopl_eg_pkg::*;
#(
  parameter int unsigned SLOTS = 18,
  parameter int unsigned CNTW  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            zero,
  input  logic [4:0]      base_rate,
  input  logic [2:0]      state_next,
  input  logic            ksr,
  input  logic [3:0]      keycode,
  output logic [9:0]      eg_out,
  output logic [2:0]      state_out,
  output logic [CNTW-1:0] eg_cnt
);

  eg_slot_t        store_q [SLOTS];
  eg_slot_t        head;
  eg_slot_t        head_d;
  logic [CNTW-1:0] eg_cnt_q;
  logic [CNTW-1:0] eg_cnt_d;
  logic [3:0]      rate;
  logic [2:0]      inc;
  eg_state_e       nx_state;
  logic [12:0]     att_prod;
  logic [9:0]      att_dec;
  logic [10:0]     rel_sum;

  assign head      = store_q[SLOTS-1];
  assign eg_out    = head.eg;
  assign state_out = head.state;
  assign eg_cnt    = eg_cnt_q;
  assign nx_state  = eg_state_e'(state_next);

  jtopl_eg_step #(.CNTW(CNTW)) u_step (
    .base_rate_i (base_rate),
    .ksr_i       (ksr),
    .keycode_i   (keycode),
    .eg_cnt_i    (eg_cnt_q),
    .rate_o      (rate),
    .inc_o       (inc)
  );

  // Next value of the head slot; eg only moves when the state is kept.
  always_comb begin
    head_d       = head;
    head_d.state = nx_state;
    att_prod     = 13'(head.eg) * 13'(inc);
    att_dec      = 10'(att_prod >> 3);
    rel_sum      = {1'b0, head.eg} + 11'(inc);
    eg_cnt_d     = zero ? eg_cnt_q + CNTW'(1) : eg_cnt_q;
    if (nx_state == head.state) begin
      case (head.state)
        ST_ATTACK: begin
          if (rate == 4'd15) begin
            head_d.eg = 10'd0;
          end else begin
            // small eg would never reach 0 through the shift alone
            if (att_dec == 10'd0 && inc != 3'd0 && head.eg != 10'd0)
              att_dec = 10'd1;
            head_d.eg = (att_dec >= head.eg) ? 10'd0 : head.eg - att_dec;
          end
        end
        ST_DECAY, ST_RELEASE:
          head_d.eg = (rel_sum > {1'b0, EG_MAX}) ? EG_MAX : rel_sum[9:0];
        default: head_d.eg = head.eg;
      endcase
    end
  end

  // Store shift and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        store_q[i].state <= ST_RELEASE;
        store_q[i].eg    <= EG_MAX;
      end
      eg_cnt_q <= '0;
    end else if (cen) begin
      store_q[0] <= head_d;
      for (int i = 1; i < int'(SLOTS); i++)
        store_q[i] <= store_q[i-1];
      eg_cnt_q <= eg_cnt_d;
    end
  end

endmodule

// File: tb/tb_jtopl_eg_adv.sv
// Self-checking bench for jtopl_eg_adv: a per-frame vector table on slot 0
// followed by directed multi-frame sequences (cen hold, key-scale rate,
// hold state, mid-frame reset, slow decay timing, release saturation).
module tb_jtopl_eg_adv;

  localparam int SLOTS = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        zero;
  logic [4:0]  base_rate;
  logic [2:0]  state_next;
  logic        ksr;
  logic [3:0]  keycode;
  logic [9:0]  eg_out;
  logic [2:0]  state_out;
  logic [14:0] eg_cnt;

  int checks     = 0;
  int failures   = 0;
  int pos        = 0;
  int others_bad = 0;
  int ksr_exp;

  always #5 clk = ~clk;

  jtopl_eg_adv dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .zero       (zero),
    .base_rate  (base_rate),
    .state_next (state_next),
    .ksr        (ksr),
    .keycode    (keycode),
    .eg_out     (eg_out),
    .state_out  (state_out),
    .eg_cnt     (eg_cnt)
  );

  typedef struct {
    logic [2:0] nx;
    logic [4:0] br;
    logic [9:0] eg;
    logic [2:0] st;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % SLOTS;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cen = 1'b1; zero = (pos == 0);
      state_next = 3'b000; base_rate = 5'h00; ksr = 1'b0; keycode = 4'h0;
      tick();
    end
  endtask

  // One frame starting at the current head slot, which gets the given inputs;
  // every other slot is expected idle at 3FF/RELEASE.
  task automatic run_frame(input logic [2:0] nx, input logic [4:0] br,
                           input logic ks, input logic [3:0] kc);
    for (int s = 0; s < SLOTS; s++) begin
      cen = 1'b1; zero = (pos == 0);
      if (s == 0) begin
        state_next = nx; base_rate = br; ksr = ks; keycode = kc;
      end else begin
        state_next = 3'b000; base_rate = 5'h00; ksr = 1'b0; keycode = 4'h0;
        if (eg_out != 10'h3FF || state_out != 3'b000) others_bad++;
      end
      tick();
    end
  endtask

  initial begin
    // slot 0, one row per frame; frame n sees eg_cnt = n
    tbl[0]  = '{3'b000, 5'h1F, 10'h3FF, 3'b000};
    tbl[1]  = '{3'b001, 5'h1E, 10'h3FF, 3'b001};
    tbl[2]  = '{3'b001, 5'h18, 10'h380, 3'b001};
    tbl[3]  = '{3'b001, 5'h1C, 10'h230, 3'b001};
    tbl[4]  = '{3'b001, 5'h1E, 10'h000, 3'b001};
    tbl[5]  = '{3'b010, 5'h1E, 10'h000, 3'b010};
    tbl[6]  = '{3'b010, 5'h1A, 10'h002, 3'b010};
    tbl[7]  = '{3'b100, 5'h1F, 10'h002, 3'b100};
    tbl[8]  = '{3'b100, 5'h1F, 10'h002, 3'b100};
    tbl[9]  = '{3'b000, 5'h1F, 10'h002, 3'b000};
    tbl[10] = '{3'b000, 5'h1F, 10'h006, 3'b000};
    tbl[11] = '{3'b000, 5'h00, 10'h006, 3'b000};
    tbl[12] = '{3'b000, 5'h14, 10'h007, 3'b000};
    tbl[13] = '{3'b000, 5'h14, 10'h007, 3'b000};
    tbl[14] = '{3'b000, 5'h17, 10'h008, 3'b000};
    tbl[15] = '{3'b000, 5'h17, 10'h008, 3'b000};
    tbl[16] = '{3'b000, 5'h14, 10'h008, 3'b000};
    tbl[17] = '{3'b001, 5'h1F, 10'h008, 3'b001};
    tbl[18] = '{3'b001, 5'h18, 10'h007, 3'b001};
    tbl[19] = '{3'b001, 5'h18, 10'h006, 3'b001};
    tbl[20] = '{3'b001, 5'h1F, 10'h000, 3'b001};

    rst = 1'b1; cen = 1'b0; zero = 1'b0;
    state_next = 3'b000; base_rate = 5'h00; ksr = 1'b0; keycode = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset eg_out", int'(eg_out), 'h3FF);
    check("reset state_out", int'(state_out), 0);
    check("reset eg_cnt", int'(eg_cnt), 0);
    rst = 1'b0; pos = 0;

    for (int i = 0; i < 21; i++) begin
      run_frame(tbl[i].nx, tbl[i].br, 1'b0, 4'h0);
      check($sformatf("row%0d eg", i), int'(eg_out), int'(tbl[i].eg));
      check($sformatf("row%0d state", i), int'(state_out), int'(tbl[i].st));
    end
    check("table eg_cnt", int'(eg_cnt), 21);
    check("table other slots", others_bad, 0);

    // cen low with zero high and an active release rate: nothing may move
    cen = 1'b0; zero = 1'b1; state_next = 3'b000; base_rate = 5'h1F;
    repeat (100) @(posedge clk);
    #1;
    check("cen hold eg", int'(eg_out), 0);
    check("cen hold state", int'(state_out), 1);
    check("cen hold eg_cnt", int'(eg_cnt), 21);

    // key-scale rate: 32 frames over eg_cnt 22..53
`ifdef JTOPL_EG_KSR_EN
    ksr_exp = 14;
`else
    ksr_exp = 1;
`endif
    run_frame(3'b000, 5'h00, 1'b0, 4'h0);
    repeat (32) run_frame(3'b000, 5'h10, 1'b1, 4'hF);
    check("ksr step count", int'(eg_out), ksr_exp);

    run_frame(3'b100, 5'h1F, 1'b0, 4'h0);
    run_frame(3'b100, 5'h1F, 1'b0, 4'h0);
    run_frame(3'b100, 5'h1A, 1'b0, 4'h0);
    run_frame(3'b100, 5'h14, 1'b1, 4'hF);
    run_frame(3'b100, 5'h00, 1'b0, 4'h0);
    check("hold eg", int'(eg_out), ksr_exp);
    check("hold state", int'(state_out), 4);
    check("pre-reset eg_cnt", int'(eg_cnt), 59);

    // asynchronous reset mid-frame
    idle(5);
    #3 rst = 1'b1;
    #1;
    check("midreset eg_out", int'(eg_out), 'h3FF);
    check("midreset state_out", int'(state_out), 0);
    check("midreset eg_cnt", int'(eg_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; pos = 0; others_bad = 0;

    // slot 3: visit k sees eg_cnt = k
    idle(3);
    run_frame(3'b001, 5'h1F, 1'b0, 4'h0);
    run_frame(3'b001, 5'h1F, 1'b0, 4'h0);
    run_frame(3'b010, 5'h1F, 1'b0, 4'h0);
    check("decay entry eg", int'(eg_out), 0);
    check("decay entry state", int'(state_out), 2);
    for (int k = 4; k <= 515; k++) begin
      run_frame(3'b010, 5'h08, 1'b0, 4'h0);
      if (k == 255) check("slow decay before 256", int'(eg_out), 0);
      if (k == 256) check("slow decay at 256", int'(eg_out), 1);
    end
    check("slow decay after 512", int'(eg_out), 1);

    // release climb to 3FE, then saturate
    run_frame(3'b000, 5'h1F, 1'b0, 4'h0);
    run_frame(3'b000, 5'h18, 1'b0, 4'h0);
    repeat (510) run_frame(3'b000, 5'h1A, 1'b0, 4'h0);
    check("release 3FE", int'(eg_out), 'h3FE);
    run_frame(3'b000, 5'h1F, 1'b0, 4'h0);
    check("release saturate", int'(eg_out), 'h3FF);
    run_frame(3'b000, 5'h1F, 1'b0, 4'h0);
    check("release stays max", int'(eg_out), 'h3FF);
    check("release state", int'(state_out), 0);
    check("late other slots", others_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
